// File: rtl/alu_multicycle.sv
// Registered ALU with a start/done handshake. Logic and shift ops finish in one cycle.
// Multiply and divide iterate WIDTH cycles on operand magnitudes, then fix the signs.
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iStart,
  input  logic [CTRL_W-1:0] iControl,
  input  logic [WIDTH-1:0]  iA,
  input  logic [WIDTH-1:0]  iB,
  output logic [WIDTH-1:0]  oResult,
  output logic              oZero,
  output logic              oBusy,
  output logic              oDone,
  output logic [1:0]        oState
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OPAND    = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OPOR     = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OPXOR    = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OPADD    = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] OPSUB    = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] OPSLT    = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] OPSLTU   = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OPSLL    = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] OPSRL    = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] OPSRA    = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] OPMUL    = CTRL_W'(10);
  localparam logic [CTRL_W-1:0] OPMULH   = CTRL_W'(11);
  localparam logic [CTRL_W-1:0] OPMULHSU = CTRL_W'(12);
  localparam logic [CTRL_W-1:0] OPMULHU  = CTRL_W'(13);
  localparam logic [CTRL_W-1:0] OPDIV    = CTRL_W'(14);
  localparam logic [CTRL_W-1:0] OPDIVU   = CTRL_W'(15);
  localparam logic [CTRL_W-1:0] OPREM    = CTRL_W'(16);
  localparam logic [CTRL_W-1:0] OPREMU   = CTRL_W'(17);

  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [CTRL_W-1:0]   op_q, op_d;
  logic [SH_W-1:0]     cnt_q, cnt_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d, zero_q, zero_d;

  // Accept-side decode, evaluated on the raw inputs
  logic             in_mul, in_div, in_sdiv, a_signed, b_signed, b_zero, div_ovf, go_iter;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    in_mul   = (iControl == OPMUL) || (iControl == OPMULH) ||
               (iControl == OPMULHSU) || (iControl == OPMULHU);
    in_div   = (iControl == OPDIV) || (iControl == OPDIVU) ||
               (iControl == OPREM) || (iControl == OPREMU);
    in_sdiv  = (iControl == OPDIV) || (iControl == OPREM);
    a_signed = (iControl == OPMULH) || (iControl == OPMULHSU) || in_sdiv;
    b_signed = (iControl == OPMULH) || in_sdiv;
    a_mag    = (a_signed && iA[WIDTH-1]) ? -iA : iA;
    b_mag    = (b_signed && iB[WIDTH-1]) ? -iB : iB;
    b_zero   = (iB == '0);
    div_ovf  = in_sdiv && (iA == MIN_INT) && (iB == '1);
    go_iter  = in_mul || (in_div && !b_zero && !div_ovf);
    shamt    = iB[SH_W-1:0];
    fast_res = '0;
    case (iControl)
      OPAND:  fast_res = iA & iB;
      OPOR:   fast_res = iA | iB;
      OPXOR:  fast_res = iA ^ iB;
      OPADD:  fast_res = iA + iB;
      OPSUB:  fast_res = iA - iB;
      OPSLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(iA) < $signed(iB))};
      OPSLTU: fast_res = {{(WIDTH-1){1'b0}}, (iA < iB)};
      OPSLL:  fast_res = iA << shamt;
      OPSRL:  fast_res = iA >> shamt;
      OPSRA:  fast_res = $signed(iA) >>> shamt;
      // Divide special cases only: by zero, or signed overflow
      OPDIV:  fast_res = b_zero ? '1 : iA;
      OPDIVU: fast_res = '1;
      OPREM:  fast_res = b_zero ? iA : '0;
      OPREMU: fast_res = iA;
      default: fast_res = '0;
    endcase
  end

  // One iteration: acc holds {hi, lo}; lo starts as the multiplier or dividend
  logic               run_mul, rem_ge;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub, quo, rem, final_res;
  logic [2*WIDTH-1:0] step, prod;

  always_comb begin
    run_mul = (op_q == OPMUL) || (op_q == OPMULH) ||
              (op_q == OPMULHSU) || (op_q == OPMULHU);
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_ge  = (rem_sh >= {1'b0, b_q});
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    if (run_mul)
      step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (rem_ge)
      step = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
    else
      step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    prod = (a_neg_q ^ b_neg_q) ? -step : step;
    quo  = (a_neg_q ^ b_neg_q) ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    rem  = a_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    case (op_q)
      OPMUL:                      final_res = prod[WIDTH-1:0];
      OPMULH, OPMULHSU, OPMULHU:  final_res = prod[2*WIDTH-1:WIDTH];
      OPDIV, OPDIVU:              final_res = quo;
      OPREM, OPREMU:              final_res = rem;
      default:                    final_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (iStart) begin
          op_d = iControl;
          if (go_iter) begin
            state_d = S_RUN;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            b_d     = b_mag;
            a_neg_d = a_signed && iA[WIDTH-1];
            b_neg_d = b_signed && iB[WIDTH-1];
            cnt_d   = '0;
          end else begin
            state_d  = S_DONE;
            result_d = fast_res;
            zero_d   = (fast_res == '0);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = step;
        cnt_d = cnt_q + SH_W'(1);
        if (cnt_q == SH_W'(WIDTH-1)) begin
          state_d  = S_DONE;
          result_d = final_res;
          zero_d   = (final_res == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign oResult = result_q;
  assign oZero   = zero_q;
  assign oBusy   = (state_q == S_RUN);
  assign oDone   = (state_q == S_DONE);
  assign oState  = state_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table at WIDTH=32, hand sequences for
// reset mid-RUN, ignored starts, back-to-back handshakes, and a WIDTH=16 instance.
module tb_alu_multicycle;

  localparam logic [4:0] OPAND = 5'd0, OPOR = 5'd1, OPXOR = 5'd2, OPADD = 5'd3,
                         OPSUB = 5'd4, OPSLT = 5'd5, OPSLTU = 5'd6, OPSLL = 5'd7,
                         OPSRL = 5'd8, OPSRA = 5'd9, OPMUL = 5'd10, OPMULH = 5'd11,
                         OPMULHSU = 5'd12, OPMULHU = 5'd13, OPDIV = 5'd14,
                         OPDIVU = 5'd15, OPREM = 5'd16, OPREMU = 5'd17, OPBAD = 5'd31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic        start = 1'b0;
  logic [4:0]  ctrl = '0;
  logic [31:0] a_in = '0, b_in = '0, res;
  logic        zero, busy, done;
  logic [1:0]  st;

  alu_multicycle #(.WIDTH(32), .CTRL_W(5)) dut (
    .iCLK(clk), .iRSTn(rst_n), .iStart(start), .iControl(ctrl), .iA(a_in), .iB(b_in),
    .oResult(res), .oZero(zero), .oBusy(busy), .oDone(done), .oState(st)
  );

  logic        s16_start = 1'b0;
  logic [4:0]  s16_ctrl = '0;
  logic [15:0] s16_a = '0, s16_b = '0, s16_res;
  logic        s16_zero, s16_busy, s16_done;
  logic [1:0]  s16_st;

  alu_multicycle #(.WIDTH(16), .CTRL_W(5)) dut16 (
    .iCLK(clk), .iRSTn(rst_n), .iStart(s16_start), .iControl(s16_ctrl), .iA(s16_a),
    .iB(s16_b), .oResult(s16_res), .oZero(s16_zero), .oBusy(s16_busy), .oDone(s16_done),
    .oState(s16_st)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Starts one op; if chain, start is raised in the current (done) cycle.
  // poke_at > 0 raises a stray ADD start at that cycle after acceptance.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name,
                        input bit chain, input int poke_at);
    int n;
    int busy_n;
    logic [31:0] want;
    if (!chain) @(negedge clk);
    start = 1'b1; ctrl = op; a_in = a; b_in = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    busy_n = 0;
    if (lat > 1) chk({name, " hold"}, {32'h0, res}, {32'h0, prev_res});
    while (!done && n < 200) begin
      if (busy) busy_n++;
      if (n == poke_at) begin
        start = 1'b1; ctrl = OPADD; a_in = 32'h1; b_in = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    want = exp_q.pop_front();
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, {32'h0, res}, {32'h0, want});
    chk({name, " zero"}, {63'h0, zero}, {63'h0, (want == 32'h0)});
    chk({name, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
    chk({name, " busy@done"}, {63'h0, busy}, 64'h0);
    prev_res = want;
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int lat, input string name);
    int n;
    int busy_n;
    @(negedge clk);
    s16_start = 1'b1; s16_ctrl = op; s16_a = a; s16_b = b;
    @(negedge clk);
    s16_start = 1'b0;
    n = 1;
    busy_n = 0;
    while (!s16_done && n < 200) begin
      if (s16_busy) busy_n++;
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " result"}, {48'h0, s16_res}, {48'h0, exp});
    chk({name, " busy cycles"}, 64'(busy_n), 64'(lat - 1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int done_n;
    // fast ops
    add_vec(OPADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    add_vec(OPSUB,    32'h00000005, 32'h00000005, 32'h00000000, 1);
    add_vec(OPSLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    add_vec(OPSLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    add_vec(OPSRA,    32'h80000000, 32'h00000021, 32'hC0000000, 1);
    add_vec(OPAND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
    add_vec(OPOR,     32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1);
    add_vec(OPXOR,    32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1);
    add_vec(OPSLL,    32'h00000001, 32'h0000001F, 32'h80000000, 1);
    add_vec(OPSRL,    32'h80000000, 32'h00000004, 32'h08000000, 1);
    add_vec(OPBAD,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    // multiply
    add_vec(OPMUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    add_vec(OPMULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    add_vec(OPMULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    add_vec(OPMULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    add_vec(OPMUL,    32'd12345,    32'd1000,     32'h00BC5EA8, 33);
    add_vec(OPMULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33);
    // divide
    add_vec(OPDIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    add_vec(OPREM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    add_vec(OPDIVU,   32'd100,      32'd7,        32'd14,       33);
    add_vec(OPREMU,   32'd100,      32'd7,        32'd2,        33);
    add_vec(OPDIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    add_vec(OPREM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    add_vec(OPDIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33);
    add_vec(OPDIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    add_vec(OPREMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    // divide special cases
    add_vec(OPDIV,    32'd9,        32'd0,        32'hFFFFFFFF, 1);
    add_vec(OPREM,    32'd9,        32'd0,        32'd9,        1);
    add_vec(OPDIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
    add_vec(OPREMU,   32'd9,        32'd0,        32'd9,        1);
    add_vec(OPDIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add_vec(OPREM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset result", {32'h0, res}, 64'h0);
    chk("reset zero", {63'h0, zero}, 64'h1);
    chk("reset busy", {63'h0, busy}, 64'h0);
    chk("reset done", {63'h0, done}, 64'h0);
    chk("reset state", {62'h0, st}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i), 1'b0, 0);

    // reset during RUN: no partial result, no completion
    @(negedge clk);
    start = 1'b1; ctrl = OPDIVU; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst state", {62'h0, st}, 64'h0);
    chk("midrst result", {32'h0, res}, 64'h0);
    chk("midrst zero", {63'h0, zero}, 64'h1);
    chk("midrst busy", {63'h0, busy}, 64'h0);
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) done_n++;
      @(negedge clk);
    end
    chk("midrst no done", 64'(done_n), 64'h0);
    prev_res = 32'h0;
    run_op(OPADD, 32'd2, 32'd3, 32'd5, 1, "post-reset add", 1'b0, 0);

    // stray start during RUN is ignored
    run_op(OPMUL, 32'd12345, 32'd1000, 32'h00BC5EA8, 33, "poked mul", 1'b0, 5);

    // back-to-back: fast ops accepted in the done cycle
    run_op(OPMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, "b2b mul", 1'b0, 0);
    run_op(OPADD, 32'd10, 32'd20, 32'd30, 1, "b2b add", 1'b1, 0);
    run_op(OPSUB, 32'd7, 32'd7, 32'd0, 1, "b2b sub", 1'b1, 0);
    run_op(OPDIVU, 32'd100, 32'd7, 32'd14, 33, "b2b divu", 1'b1, 0);

    // WIDTH = 16
    run16(OPMULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17, "w16 mulhu");
    run16(OPDIV, 16'hFFF9, 16'h0002, 16'hFFFD, 17, "w16 div");
    run16(OPSRA, 16'h8000, 16'h0011, 16'hC000, 1, "w16 sra");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised successor to the single-cycle datapath ALU: a registered ALU with start/done handshake. Adds XOR, unsigned compare, shifts, and iterative RV32M-style multiply/divide/remainder. Sits in the multicycle and pipelined cores' EX stage; the control unit stalls on `oBusy`. Operation codes are named constants in `Parametros.v`; the new codes are added there with unique values.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4 and a power of two.
- `CTRL_W`, 5: width of `iControl`.
- `iCLK` input 1: clock; all state updates on rising edge.
- `iRSTn` input 1: synchronous reset, active-low, sampled on `iCLK` rising edge.
- `iStart` input 1: request; sampled only in IDLE or DONE.
- `iControl` input CTRL_W: operation code, latched on accepted start.
- `iA`, `iB` input WIDTH: operands, latched on accepted start.
- `oResult` output WIDTH: registered result; holds until the next completion.
- `oZero` output 1: registered, 1 when the latched `oResult` == 0.
- `oBusy` output 1: 1 while in RUN.
- `oDone` output 1: one-cycle pulse when `oResult` becomes valid.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE with `iStart`=1 and an iterative op → RUN.
  - IDLE or DONE with `iStart`=1 and a fast op → DONE.
  - RUN → DONE after exactly WIDTH iteration cycles.
  - DONE with `iStart`=0 → IDLE.
- Fast ops (result computed from latched operands, written in the accept cycle):
  - OPAND, OPOR, OPXOR, OPADD, OPSUB: wrap-around modulo 2^WIDTH.
  - OPSLT: signed compare. OPSLTU: unsigned compare. Result is 1 or 0, zero-extended.
  - OPSLL, OPSRL, OPSRA: shift amount is `iB[log2(WIDTH)-1:0]`; upper bits are ignored.
  - Undefined codes: result 0.
- Iterative ops:
  - OPMUL returns the low WIDTH bits of the product.
  - OPMULH, OPMULHSU, OPMULHU return the high WIDTH bits for signed×signed, signed×unsigned and unsigned×unsigned operands.
  - Multiply is shift-add on a 2·WIDTH accumulator; operands are sign-handled per op.
  - OPDIV, OPDIVU return the quotient; OPREM, OPREMU return the remainder.
  - Divide is restoring, one quotient bit per cycle, on magnitudes; signs are corrected in the last RUN cycle.
  - Signed division truncates toward zero. The remainder takes the dividend's sign.
- Divide special cases take the fast path (DONE next cycle, no RUN):
  - Divide by zero: quotient is all ones; remainder = dividend.
  - Signed overflow (A = −2^(WIDTH−1), B = −1): quotient = A; remainder = 0.
- `iStart` in RUN is ignored; latched operands are not disturbed.
- Reset (any state, including mid-RUN):
  - Next state is IDLE.
  - `oResult`=0, `oZero`=1, `oBusy`=0, `oDone`=0.
  - Internal accumulators are cleared.
  - A partial result is never presented.

## Timing
- Start accepted in cycle T.
- Fast op: `oResult`, `oZero` valid and `oDone`=1 in cycle T+1.
- Iterative op:
  - `oBusy`=1 in cycles T+1 through T+WIDTH.
  - `oDone`=1 and `oResult` valid in cycle T+WIDTH+1.
  - `oBusy`=0 in the `oDone` cycle.
- Back-to-back: `iStart`=1 in the `oDone` cycle is accepted.
  - The next fast result pulses `oDone` again in the following cycle, so `oDone` may stay high across consecutive fast ops.
  - Every completion is exactly one pulse-cycle.
- `oResult` and `oZero` change only on a completion or on reset.

## Test plan
- Reset, then fast ops:
  - OPADD 0x7FFFFFFF + 1 → 0x80000000, `oDone` at T+1.
  - OPSUB 5 − 5 → 0, `oZero`=1.
  - OPSLTU 0xFFFFFFFF < 1 → 0.
  - OPSLT same operands → 1.
  - OPSRA 0x80000000 by 0x21 → 0xC0000000, because only the low 5 bits of B are used.
- Multiply:
  - OPMUL 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
  - OPMULHU same operands → 0xFFFFFFFE.
  - OPMULH same operands → 0x00000000.
  - `oBusy` high for exactly 32 cycles; `oDone` at T+33.
- Divide:
  - OPDIV −7 / 2 → −3; OPREM −7 % 2 → −1.
  - OPDIVU 100 / 7 → 14; OPREMU 100 % 7 → 2.
- Divide special cases:
  - OPDIV 9 / 0 → 0xFFFFFFFF; OPREM 9 % 0 → 9.
  - OPDIV 0x80000000 / −1 → 0x80000000; OPREM same → 0.
  - All complete with `oDone` at T+1.
- Reset mid-RUN:
  - Start OPDIVU; deassert `iRSTn` at T+10.
  - Next cycle: IDLE, `oResult`=0, `oZero`=1, `oBusy`=0.
  - No `oDone` follows.
  - A fresh OPADD 2+3 → 5 at T+1.
- Handshake:
  - `iStart` pulsed during RUN is ignored and the result is unchanged.
  - OPMUL followed by OPADD started in the `oDone` cycle → OPADD result one cycle later.
  - Repeat with WIDTH=16: OPMULHU 0xFFFF × 0xFFFF → 0xFFFE, `oDone` at T+17.
